input_current_accumulator: RTL and testbench

//  Multi-cycle, parametrised synaptic current calculator for one SNN neuron.
//  On a start pulse, captures M spike bits and M signed weights, then sums the

---
 rtl/snn_pkg.sv | 19 +
 rtl/spike_weight_lane_sum.sv | 25 ++
 rtl/input_current_accumulator.sv | 133 +++++++++++++
 tb/tb_input_current_accumulator.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared widths, helper function and FSM state type for the SNN neuron datapath.
package snn_pkg;

    localparam int unsigned DefW    = 8;
    localparam int unsigned DefOutW = 8;

    typedef enum logic {StIdle, StAccum} acc_state_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((longint'(1) << i) < longint'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/spike_weight_lane_sum.sv
// Combinational signed sum of LANES weights, each gated by its spike bit.
module spike_weight_lane_sum
    import snn_pkg::*;
#(
    parameter int unsigned LANES = 4,
    parameter int unsigned W     = DefW,
    parameter int unsigned SUM_W = 14
) (
    input  logic [LANES-1:0]       i_spikes,
    input  logic [LANES*W-1:0]     i_weights,
    output logic signed [SUM_W-1:0] o_lane_sum
);

    logic signed [SUM_W-1:0] w_ext;

    always_comb begin
        o_lane_sum = '0;
        w_ext      = '0;
        for (int i = 0; i < LANES; i++) begin
            w_ext = {{(SUM_W-W){i_weights[i*W+W-1]}}, i_weights[i*W +: W]};
            if (i_spikes[i]) o_lane_sum = o_lane_sum + w_ext;
        end
    end

endmodule

// File: rtl/input_current_accumulator.sv
// Multi-cycle synaptic current accumulator: captures spikes/weights on start and
// sums LANES gated weights per cycle, then saturates or wraps to OUT_W bits.
module input_current_accumulator
    import snn_pkg::*;
#(
    parameter int unsigned M        = 24,
    parameter int unsigned W        = DefW,
    parameter int unsigned LANES    = 4,
    parameter int unsigned OUT_W    = DefOutW,
    parameter int unsigned SATURATE = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [M-1:0]            input_spikes,
    input  logic [M*W-1:0]          weights,
    output logic                    busy,
    output logic                    done,
    output logic signed [OUT_W-1:0] input_current,
    output logic                    saturated
);

    localparam int unsigned NCHUNK = (M + LANES - 1) / LANES;
    localparam int unsigned SUM_W  = W + clog2(M) + 1;
    localparam int unsigned CNT_W  = (NCHUNK > 1) ? clog2(NCHUNK) : 1;
    localparam int unsigned PAD_M  = NCHUNK * LANES;
    localparam int          MaxI   = (1 << (OUT_W - 1)) - 1;
    localparam logic signed [SUM_W-1:0] MaxOut = SUM_W'(MaxI);
    localparam logic signed [SUM_W-1:0] MinOut = SUM_W'(-MaxI - 1);

    acc_state_e              r_state;
    logic [M-1:0]            r_spikes;
    logic [M*W-1:0]          r_weights;
    logic signed [SUM_W-1:0] r_acc;
    logic [CNT_W-1:0]        r_chunk;
    logic                    r_busy;
    logic                    r_done;
    logic signed [OUT_W-1:0] r_current;
    logic                    r_sat;

    logic [PAD_M-1:0]        w_spk_pad;
    logic [PAD_M*W-1:0]      w_wgt_pad;
    logic [LANES-1:0]        w_chunk_spk;
    logic [LANES*W-1:0]      w_chunk_wgt;
    logic signed [SUM_W-1:0] w_lane_sum;
    logic signed [SUM_W-1:0] w_total;
    logic signed [OUT_W-1:0] w_next_cur;
    logic                    w_next_sat;

    // Zero padding makes lanes beyond M contribute nothing in a partial last chunk.
    always_comb begin
        w_spk_pad            = '0;
        w_spk_pad[M-1:0]     = r_spikes;
        w_wgt_pad            = '0;
        w_wgt_pad[M*W-1:0]   = r_weights;
    end

    assign w_chunk_spk = w_spk_pad[r_chunk*LANES +: LANES];
    assign w_chunk_wgt = w_wgt_pad[r_chunk*LANES*W +: LANES*W];

    spike_weight_lane_sum #(
        .LANES (LANES),
        .W     (W),
        .SUM_W (SUM_W)
    ) u_lane_sum (
        .i_spikes   (w_chunk_spk),
        .i_weights  (w_chunk_wgt),
        .o_lane_sum (w_lane_sum)
    );

    assign w_total = r_acc + w_lane_sum;

    always_comb begin
        w_next_cur = w_total[OUT_W-1:0];
        w_next_sat = 1'b0;
        if (SATURATE != 0) begin
            if (w_total > MaxOut) begin
                w_next_cur = MaxOut[OUT_W-1:0];
                w_next_sat = 1'b1;
            end else if (w_total < MinOut) begin
                w_next_cur = MinOut[OUT_W-1:0];
                w_next_sat = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= StIdle;
            r_spikes  <= '0;
            r_weights <= '0;
            r_acc     <= '0;
            r_chunk   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_current <= '0;
            r_sat     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_spikes  <= input_spikes;
                        r_weights <= weights;
                        r_acc     <= '0;
                        r_chunk   <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= StAccum;
                    end
                end
                StAccum: begin
                    if (r_chunk == CNT_W'(NCHUNK - 1)) begin
                        r_current <= w_next_cur;
                        r_sat     <= w_next_sat;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= StIdle;
                    end else begin
                        r_acc   <= w_total;
                        r_chunk <= r_chunk + CNT_W'(1);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign input_current = r_current;
    assign saturated     = r_sat;

endmodule

// File: tb/tb_input_current_accumulator.sv
// Directed self-checking bench: default 24-input instance plus a 10-input wrapping instance.
module tb_input_current_accumulator;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start0, start1;
    logic [23:0]  spikes0;
    logic [191:0] weights0;
    logic [9:0]   spikes1;
    logic [79:0]  weights1;
    logic         busy0, done0, sat0, busy1, done1, sat1;
    logic [7:0]   ic0, ic1;

    int checks = 0;
    int errors = 0;
    int n, nb, cnt;

    always #5 clk = ~clk;

    input_current_accumulator #(
        .M(24), .W(8), .LANES(4), .OUT_W(8), .SATURATE(1)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .start(start0), .input_spikes(spikes0),
        .weights(weights0), .busy(busy0), .done(done0), .input_current(ic0),
        .saturated(sat0)
    );

    input_current_accumulator #(
        .M(10), .W(8), .LANES(4), .OUT_W(8), .SATURATE(0)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .input_spikes(spikes1),
        .weights(weights1), .busy(busy1), .done(done1), .input_current(ic1),
        .saturated(sat1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        step();
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    // Cycles from the start-sampling edge until done, plus busy-high samples seen.
    task automatic wait_done(input bit sel, output int cyc, output int nbusy);
        cyc   = 0;
        nbusy = (sel ? busy1 : busy0) ? 1 : 0;
        while (!(sel ? done1 : done0) && cyc < 20) begin
            step();
            cyc++;
            if (sel ? busy1 : busy0) nbusy++;
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        start0   = 1'b0;
        start1   = 1'b0;
        spikes0  = '0;
        weights0 = '0;
        spikes1  = '0;
        weights1 = '0;
        step();
        step();
        reset_n = 1'b1;
        step();
        chk("reset_busy", busy0, 0);
        chk("reset_done", done0, 0);
        chk("reset_ic", ic0, 8'h00);
        chk("reset_sat", sat0, 0);
        chk("reset_ic1", ic1, 8'h00);

        // 1: 24 x 5 = 120
        spikes0  = 24'hFFFFFF;
        weights0 = {24{8'd5}};
        pulse_start(0);
        chk("t1_busy_after_start", busy0, 1);
        wait_done(0, n, nb);
        chk("t1_latency", n, 6);
        chk("t1_busy_cycles", nb, 6);
        chk("t1_ic", ic0, 8'd120);
        chk("t1_sat", sat0, 0);
        spikes0 = '0;
        step();
        chk("t1_done_one_cycle", done0, 0);
        chk("t1_ic_held", ic0, 8'd120);

        // 2: positive and negative saturation
        spikes0  = 24'hFFFFFF;
        weights0 = {24{8'd100}};
        pulse_start(0);
        wait_done(0, n, nb);
        chk("t2_pos_latency", n, 6);
        chk("t2_pos_ic", ic0, 8'h7F);
        chk("t2_pos_sat", sat0, 1);
        weights0 = {24{8'h9C}};
        pulse_start(0);
        wait_done(0, n, nb);
        chk("t2_neg_ic", ic0, 8'h80);
        chk("t2_neg_sat", sat0, 1);

        // 3: single active spike, then no spikes
        spikes0  = 24'h000001;
        weights0 = {{23{8'd50}}, 8'hF9};
        pulse_start(0);
        wait_done(0, n, nb);
        chk("t3_one_ic", ic0, 8'hF9);
        chk("t3_one_sat", sat0, 0);
        spikes0 = 24'h000000;
        pulse_start(0);
        wait_done(0, n, nb);
        chk("t3_zero_ic", ic0, 8'h00);
        chk("t3_zero_sat", sat0, 0);

        // 4: start held high; inputs during busy must be ignored
        spikes0  = 24'hFFFFFF;
        weights0 = {24{8'd5}};
        start0   = 1'b1;
        step();
        weights0 = {24{8'd3}};
        wait_done(0, n, nb);
        chk("t4_first_latency", n, 6);
        chk("t4_first_ic", ic0, 8'd120);
        weights0 = {24{8'd1}};
        step();
        chk("t4_restart_busy", busy0, 1);
        weights0 = {24{8'd3}};
        wait_done(0, n, nb);
        chk("t4_period", n + 1, 7);
        chk("t4_second_ic", ic0, 8'd24);
        start0 = 1'b0;
        step();

        // 5: reset in the middle of accumulation after a saturating result
        weights0 = {24{8'd100}};
        pulse_start(0);
        wait_done(0, n, nb);
        chk("t5_pre_sat", sat0, 1);
        pulse_start(0);
        step();
        step();
        step();
        reset_n = 1'b0;
        #1;
        chk("t5_rst_busy", busy0, 0);
        chk("t5_rst_done", done0, 0);
        chk("t5_rst_ic", ic0, 8'h00);
        chk("t5_rst_sat", sat0, 0);
        #3;
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done0) cnt++;
        end
        chk("t5_no_done", cnt, 0);
        weights0 = {24{8'd2}};
        pulse_start(0);
        wait_done(0, n, nb);
        chk("t5_after_latency", n, 6);
        chk("t5_after_ic", ic0, 8'd48);

        // 6: M=10 wrapping instance, partial last chunk
        spikes1  = 10'h3FF;
        weights1 = {10{8'd20}};
        pulse_start(1);
        wait_done(1, n, nb);
        chk("t6_latency", n, 3);
        chk("t6_busy_cycles", nb, 3);
        chk("t6_ic", ic1, 8'hC8);
        chk("t6_sat", sat1, 0);
        weights1 = {10{8'hEC}};
        pulse_start(1);
        wait_done(1, n, nb);
        chk("t6_neg_ic", ic1, 8'h38);
        chk("t6_neg_sat", sat1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
